// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr: registered fixed/round-robin priority encoder with valid/ready output
// clk, rst : clock, synchronous active-high reset
// en, mode : sample enable; 0 = fixed priority (MSB highest), 1 = round-robin
// req      : request vector, sampled when req_ready is high
// req_ready: combinational, high when req is sampled this cycle
// out_*    : registered grant (valid, binary index, one-hot) with out_ready handshake
module priority_encoder_rr #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] req,
  output logic             req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_gnt
);
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_gnt;
  logic [IDX_W-1:0] r_top;
  logic [IDX_W-1:0] w_fix;
  logic [IDX_W-1:0] w_lo;
  logic             w_hit;
  logic [IDX_W-1:0] w_g;
  logic             w_load;
  // Round-robin order top..0 then WIDTH-1..top+1 reduces to: highest set bit at or
  // below top if any, otherwise the highest set bit overall.
  always_comb begin
    w_fix = '0;
    w_lo  = '0;
    w_hit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) w_fix = IDX_W'(i);
      if (req[i] && i <= int'(r_top)) begin
        w_lo  = IDX_W'(i);
        w_hit = 1'b1;
      end
    end
  end
  assign w_g       = (mode && w_hit) ? w_lo : w_fix;
  assign req_ready = en & (~r_valid | out_ready);
  assign w_load    = req_ready & (|req);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_top   <= IDX_W'(WIDTH-1);
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_idx   <= w_g;
      r_gnt   <= WIDTH'(1) << w_g;
      if (mode) r_top <= (w_g == '0) ? IDX_W'(WIDTH-1) : w_g - 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign out_gnt   = r_gnt;
endmodule

// File: tb/tb_priority_encoder_rr.sv
module tb_priority_encoder_rr;
  logic       clk = 1'b0;
  logic       rst, en, mode, out_ready;
  logic [7:0] req;
  logic       req_ready, out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_gnt;
  logic       en5, mode5, out_ready5;
  logic [4:0] req5;
  logic       req_ready5, out_valid5;
  logic [2:0] out_idx5;
  logic [4:0] out_gnt5;
  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  priority_encoder_rr #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_gnt(out_gnt)
  );

  priority_encoder_rr #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .en(en5), .mode(mode5), .req(req5), .req_ready(req_ready5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_idx(out_idx5), .out_gnt(out_gnt5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop8(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty_q"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_idx"}, 32'(out_idx), e);
    chk({tag, "_gnt"}, 32'(out_gnt), 32'(8'(1) << e));
  endtask

  task automatic pop5(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty_q"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(out_valid5), 1);
    chk({tag, "_idx"}, 32'(out_idx5), e);
    chk({tag, "_gnt"}, 32'(out_gnt5), 32'(5'(1) << e));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; req = '0; out_ready = 1'b1;
    en5 = 1'b1; mode5 = 1'b1; req5 = '0; out_ready5 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_gnt", 32'(out_gnt), 0);
    chk("rst_top", 32'(u8.r_top), 7);
    chk("rst_ready_en0", 32'(req_ready), 0);
    en = 1'b1;
    #1;
    chk("rst_ready_en1", 32'(req_ready), 1);

    req = 8'b0010_1100; exp_q.push_back(5);
    tick();
    pop8("fixed");
    req = '0;
    tick();
    chk("fixed_drop", 32'(out_valid), 0);
    chk("fixed_top_hold", 32'(u8.r_top), 7);

    mode = 1'b1; req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back((7 - k + 8) % 8);
      tick();
      pop8($sformatf("rr_full%0d", k));
    end

    req = '0; rst = 1'b1;
    tick();
    rst = 1'b0; req = 8'b1000_0001;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back((k % 2 == 0) ? 7 : 0);
      tick();
      pop8($sformatf("rr_sparse%0d", k));
    end

    req = 8'h08; exp_q.push_back(3);
    tick();
    pop8("bp_load3");
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req = (k % 2 == 0) ? 8'hF0 : 8'h01;
      #1;
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 0);
      tick();
      chk($sformatf("bp_valid%0d", k), 32'(out_valid), 1);
      chk($sformatf("bp_idx%0d", k), 32'(out_idx), 3);
      chk($sformatf("bp_top%0d", k), 32'(u8.r_top), 2);
    end
    out_ready = 1'b1; req = 8'h01;
    #1;
    chk("bp_release_ready", 32'(req_ready), 1);
    exp_q.push_back(0);
    tick();
    pop8("bp_release");

    req = '0;
    tick();
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_idx_kept", 32'(out_idx), 0);
    chk("idle_top", 32'(u8.r_top), 7);
    en = 1'b0; req = 8'hFF;
    #1;
    chk("dis_ready", 32'(req_ready), 0);
    tick();
    chk("dis_valid", 32'(out_valid), 0);
    chk("dis_top", 32'(u8.r_top), 7);

    en = 1'b1; exp_q.push_back(7);
    tick();
    pop8("sw_rr");
    mode = 1'b0; exp_q.push_back(7);
    tick();
    pop8("sw_fixed");
    chk("sw_top_held", 32'(u8.r_top), 6);
    mode = 1'b1; exp_q.push_back(6);
    tick();
    pop8("sw_rr_again");

    req = 8'h10; exp_q.push_back(4);
    tick();
    pop8("mid_g4");
    out_ready = 1'b0; rst = 1'b1; req = 8'hFF;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_idx", 32'(out_idx), 0);
    chk("mid_rst_gnt", 32'(out_gnt), 0);
    chk("mid_rst_top", 32'(u8.r_top), 7);
    rst = 1'b0; out_ready = 1'b1;
    exp_q.push_back(7);
    tick();
    pop8("mid_first");

    req = '0;
    req5 = 5'b10001;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back((k % 2 == 0) ? 4 : 0);
      tick();
      pop5($sformatf("w5_%0d", k));
      if (k == 1) chk("w5_top_wrap", 32'(u5.r_top), 4);
    end
    req5 = '0;
    chk("q_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/priority_encoder_rr.md
# priority_encoder_rr

Parametrised, registered successor to the 8-to-3 priority encoder. It accepts a `WIDTH`-bit request vector and selects one set bit. Selection is either fixed-priority (MSB highest) or round-robin, chosen at run time. The result is a binary index plus a one-hot grant, held in an output register with a valid/ready handshake. It sits between request sources and any consumer that serves one requester per transfer and may stall.

## Interface
- `WIDTH`, 8: number of request lines; legal range ≥ 2, powers of two not required.
- `IDX_W`, `$clog2(WIDTH)`: width of the index output; derived, not overridden.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  enable; when 0, no new request is sampled.
- `mode`  in  1  0 = fixed priority (bit `WIDTH-1` highest); 1 = round-robin.
- `req`  in  `WIDTH`  request vector, level-sensitive, sampled when `req_ready`=1.
- `req_ready`  out  1  combinational; 1 when `req` is sampled this cycle.
- `out_valid`  out  1  output register holds a grant.
- `out_ready`  in  1  consumer accepts the grant this cycle.
- `out_idx`  out  `IDX_W`  binary index of the granted bit.
- `out_gnt`  out  `WIDTH`  one-hot grant; bit `out_idx` set.

## Operation
- `req_ready = en & (~out_valid | out_ready)`.
- `load = req_ready & (req != 0)`.
- **Fixed mode:** the grant is the highest set bit of `req`. This matches the previous encoder's encoding: `8'b1???????` gives index 7, down to `8'b00000001` giving index 0.
- **Round-robin mode:** an internal pointer `top` (`IDX_W` bits) names the highest-priority index.
  - Search order is `top`, `top-1`, …, 0, then `WIDTH-1`, …, `top+1`.
  - The first set bit in that order is granted.
- **Pointer update:** on a load in round-robin mode with grant `g`, `top <= (g==0) ? WIDTH-1 : g-1`.
  - Wrap is always to `WIDTH-1`, never to `2^IDX_W-1`.
- **Pointer hold:** in fixed mode, `top` is held unchanged; no update occurs.
- **On load:** `out_valid <= 1`, `out_idx <= g`, `out_gnt <= 1<<g`.
- **On accept without load** (`out_valid & out_ready & ~load`): `out_valid <= 0`. `out_idx` and `out_gnt` keep their last values.
- **Stall** (`out_valid & ~out_ready`): all outputs and `top` are held. `req` is ignored; requests are not queued.
- **`req == 0` with `en=1`:** no load and no pointer change. `out_valid` drops only via accept.
- **Mode switch:** takes effect at the next load. `top` keeps its value across switches.
- **Reset values:** `out_valid=0`, `out_idx=0`, `out_gnt=0`, `top=WIDTH-1`. `req_ready` follows from `out_valid=0` and therefore equals `en`.
- **Priority of events:** `rst` overrides load, accept and stall in the same cycle.

## Timing
- Latency is 1 cycle: `req` sampled at edge N appears on `out_*` after edge N.
- Throughput is one grant per cycle while `out_ready`=1 and `req` is non-zero. Accept and the next load happen on the same edge.
- `out_*` and `top` are registered outputs.
- `req_ready` has a combinational path from `out_ready` and `en`.
- There is no combinational path from `req` to any output.
- Reset asserted mid-stream takes effect at the next edge:
  - pending grant dropped;
  - `top` restored to `WIDTH-1`;
  - the first round-robin grant after reset with all bits requested is `WIDTH-1`.

## Test plan
- **Fixed priority:** `WIDTH=8`, `mode=0`, `en=1`, `out_ready=1`, `req=8'b0010_1100` for one cycle → next cycle `out_valid=1`, `out_idx=5`, `out_gnt=8'b0010_0000`. The following cycle `out_valid=0`.
- **Round-robin, full request:** `mode=1`, `req=8'hFF` held, `out_ready=1` → `out_idx` sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles.
- **Round-robin, sparse and non-power-of-two wrap:**
  - `WIDTH=8`, `req=8'b1000_0001` → 7,0,7,0.
  - `WIDTH=5`, `req=5'b10001` → 4,0,4. `out_idx` never exceeds 4.
- **Backpressure:**
  - With grant idx 3 valid, hold `out_ready=0` for 4 cycles while `req` toggles → `out_idx=3` stable, `req_ready=0`, `top` unchanged.
  - Raise `out_ready` with `req=8'h01` → idx 0 loads on that same edge.
- **Idle and enable:** `en=0`, or `req=0`, with `out_ready=1` → no load. A pending grant is consumed, `out_valid` falls to 0, and `top` is unchanged.
- **Reset mid-operation:** in round-robin after grant 4, assert `rst` one cycle with `out_ready=0` → all outputs 0. Then `req=8'hFF` → first grant is 7.
